// File: rtl/writeback_pkg.sv
// Shared widths and the entry type that travels from the ALU buffer to the
// register bank write port.
package writeback_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of ALU write-back entries. Full/empty come from the occupancy
// counter so the pointers can simply wrap modulo DEPTH.
module wb_fifo
  import writeback_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push_i,
  input  wb_entry_t     push_entry_i,
  input  logic          pop_i,
  output wb_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a cleared count makes every slot unreachable.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Single register-bank write port shared by load returns (always first) and
// buffered ALU results. WB_ZERO_GUARD_EN drops every entry aimed at x0.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_address,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [CW-1:0]         fifo_count
);

  wb_entry_t             alu_entry, head;
  logic                  fifo_full, fifo_empty;
  logic                  alu_push, fifo_pop, mem_take;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign alu_entry = '{address: alu_address, data: alu_data};
  assign alu_ready = !fifo_full;
  assign mem_ready = 1'b1;

`ifdef WB_ZERO_GUARD_EN
  // x0 entries are still handshaken so neither source stalls on them.
  assign alu_push = alu_valid && alu_ready && (alu_address != '0);
  assign mem_take = mem_valid && (mem_address != '0);
`else
  assign alu_push = alu_valid && alu_ready;
  assign mem_take = mem_valid;
`endif

  // A valid load owns the port even when it is discarded.
  assign fifo_pop = !mem_valid && !fifo_empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .push_i       (alu_push),
    .push_entry_i (alu_entry),
    .pop_i        (fifo_pop),
    .head_o       (head),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  always_comb begin
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (mem_take) begin
      write_d = 1'b1;
      addr_d  = mem_address;
      data_d  = mem_data;
    end else if (fifo_pop) begin
      write_d = 1'b1;
      addr_d  = head.address;
      data_d  = head.data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign write         = write_q;
  assign write_address = addr_q;
  assign write_data    = data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based model of the write port.
module tb_writeback_arbiter;
  import writeback_pkg::*;

  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;
  localparam int VW = 1 + ADDR_WIDTH + DATA_WIDTH + CW + 2;

`ifdef WB_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  alu_valid, alu_ready;
  logic [ADDR_WIDTH-1:0] alu_address;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid, mem_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  write;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [CW-1:0]         fifo_count;

  always #5 clock = ~clock;

  writeback_arbiter #(.FIFO_DEPTH(D)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_address   (alu_address),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .write         (write),
    .write_address (write_address),
    .write_data    (write_data),
    .fifo_count    (fifo_count)
  );

  // Reference model: the ALU buffer is a plain queue, the port a triple.
  wb_entry_t             mq[$];
  logic                  m_write;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_acc;
  int                    n_vec = 0;
  int                    n_bad = 0;

  logic [VW-1:0] obs_vec;
  assign obs_vec = {write, write_address, write_data, fifo_count, alu_ready, mem_ready};

  function automatic logic [VW-1:0] model_vec();
    return {m_write, m_addr, m_data, CW'(mq.size()), mq.size() != D, 1'b1};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_write = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_address = '0; mem_data = '0;
    alu_valid = 1'b0; alu_address = '0; alu_data = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return at negedge.
  task automatic step(input logic mv, input logic [ADDR_WIDTH-1:0] ma, input logic [DATA_WIDTH-1:0] md,
                      input logic av, input logic [ADDR_WIDTH-1:0] aa, input logic [DATA_WIDTH-1:0] ad);
    wb_entry_t e;
    mem_valid = mv; mem_address = ma; mem_data = md;
    alu_valid = av; alu_address = aa; alu_data = ad;
    @(posedge clock);
    m_acc = av && (mq.size() != D);
    if (mv) begin
      if (ZG && ma == '0) m_write = 1'b0;
      else begin m_write = 1'b1; m_addr = ma; m_data = md; end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_write = 1'b1; m_addr = e.address; m_data = e.data;
    end else begin
      m_write = 1'b0;
    end
    if (m_acc && !(ZG && aa == '0)) mq.push_back('{address: aa, data: ad});
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (obs_vec !== model_vec()) begin
      n_bad++; $display("FAIL reset_state: got %h expected %h", obs_vec, model_vec());
    end
    n_vec++;
    if (write !== 1'b0 || fifo_count !== '0 || alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_flags: got w=%b cnt=%0d ar=%b mr=%b expected 0 0 1 1", write, fifo_count, alu_ready, mem_ready);
    end
  endtask

  task automatic test_single_load();
    int pulses = 0;
    step(1'b1, 5'd7, 64'hDEAD_BEEF, 1'b0, '0, '0);
    n_vec++;
    if (write !== 1'b1 || write_address !== 5'd7 || write_data !== 64'hDEAD_BEEF) begin
      n_bad++; $display("FAIL single_load: got w=%b a=%0d d=%h expected 1 7 deadbeef", write, write_address, write_data);
    end
    pulses += int'(write);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0);
      pulses += int'(write);
      n_vec++;
      if (obs_vec !== model_vec()) begin
        n_bad++; $display("FAIL single_load_idle: got %h expected %h", obs_vec, model_vec());
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_bad++; $display("FAIL single_load_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_drain_order();
    logic [ADDR_WIDTH-1:0] seq[$];
    int first = -1;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) step(1'b0, '0, '0, 1'b1, ADDR_WIDTH'(k + 2), DATA_WIDTH'(k * 'h11));
      else        step(1'b0, '0, '0, 1'b0, '0, '0);
      if (write) begin
        if (first < 0) first = k;
        seq.push_back(write_address);
      end
      n_vec++;
      if (obs_vec !== model_vec()) begin
        n_bad++; $display("FAIL drain_step%0d: got %h expected %h", k, obs_vec, model_vec());
      end
    end
    n_vec++;
    if (first != 2 || seq.size() != 3) begin
      n_bad++; $display("FAIL drain_timing: got first=%0d n=%0d expected first=2 n=3", first, seq.size());
    end else begin
      n_vec++;
      if (seq[0] !== 5'd3 || seq[1] !== 5'd4 || seq[2] !== 5'd5) begin
        n_bad++; $display("FAIL drain_order: got %0d %0d %0d expected 3 4 5", seq[0], seq[1], seq[2]);
      end
    end
  endtask

  task automatic test_priority_backpressure();
    logic [ADDR_WIDTH-1:0] seq[$];
    int ai = 0;
    int c  = 0;
    while ((ai < 5 || mq.size() > 0 || c < 6) && c < 40) begin
      step(c < 6, ADDR_WIDTH'(10 + c), {$urandom, $urandom},
           ai < 5, ADDR_WIDTH'(20 + ai), {$urandom, $urandom});
      if (m_acc) ai++;
      if (write) seq.push_back(write_address);
      n_vec++;
      if (obs_vec !== model_vec()) begin
        n_bad++; $display("FAIL prio_cycle%0d: got %h expected %h", c, obs_vec, model_vec());
      end
      if (c == 3) begin
        n_vec++;
        if (alu_ready !== 1'b0 || fifo_count !== CW'(4)) begin
          n_bad++; $display("FAIL prio_full: got ar=%b cnt=%0d expected 0 4", alu_ready, fifo_count);
        end
      end
      c++;
    end
    step(1'b0, '0, '0, 1'b0, '0, '0);
    if (write) seq.push_back(write_address);
    n_vec++;
    if (c >= 40) begin
      n_bad++; $display("FAIL prio_timeout: got %0d cycles expected under 40", c);
    end
    n_vec++;
    if (seq.size() != 11) begin
      n_bad++; $display("FAIL prio_writes: got %0d expected 11", seq.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_vec++;
        if (seq[i] !== ADDR_WIDTH'(i < 6 ? 10 + i : 14 + i)) begin
          n_bad++; $display("FAIL prio_order%0d: got %0d expected %0d", i, seq[i], i < 6 ? 10 + i : 14 + i);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) step(1'b1, 5'd1, 64'h1, 1'b1, ADDR_WIDTH'(8 + i), DATA_WIDTH'(i));
    n_vec++;
    if (fifo_count !== CW'(4) || alu_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_fill: got cnt=%0d ar=%b expected 4 0", fifo_count, alu_ready);
    end
    step(1'b0, '0, '0, 1'b1, 5'd12, 64'hC);
    n_vec++;
    if (fifo_count !== CW'(3) || alu_ready !== 1'b1 || write_address !== 5'd8) begin
      n_bad++; $display("FAIL full_pop_nopush: got cnt=%0d ar=%b a=%0d expected 3 1 8", fifo_count, alu_ready, write_address);
    end
    step(1'b0, '0, '0, 1'b1, 5'd12, 64'hC);
    n_vec++;
    if (fifo_count !== CW'(3) || write_address !== 5'd9) begin
      n_bad++; $display("FAIL full_push_pop: got cnt=%0d a=%0d expected 3 9", fifo_count, write_address);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0);
      n_vec++;
      if (obs_vec !== model_vec()) begin
        n_bad++; $display("FAIL full_drain%0d: got %h expected %h", i, obs_vec, model_vec());
      end
    end
  endtask

  task automatic test_zero_addr();
    int zw = 0;
    step(1'b1, 5'd0, 64'h5, 1'b0, '0, '0);
    zw += int'(write && write_address == '0);
    step(1'b0, '0, '0, 1'b1, 5'd0, 64'h6);
    zw += int'(write && write_address == '0);
    n_vec++;
    if (obs_vec !== model_vec()) begin
      n_bad++; $display("FAIL zero_push: got %h expected %h", obs_vec, model_vec());
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0);
      zw += int'(write && write_address == '0);
    end
    n_vec++;
    if (zw != (ZG ? 0 : 2)) begin
      n_bad++; $display("FAIL zero_writes: got %0d expected %0d", zw, ZG ? 0 : 2);
    end
  endtask

  task automatic test_reset_midstream();
    int pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 5'd2, 64'h2, 1'b1, ADDR_WIDTH'(16 + i), DATA_WIDTH'(i));
    n_vec++;
    if (fifo_count !== CW'(3)) begin
      n_bad++; $display("FAIL mid_buffered: got %0d expected 3", fifo_count);
    end
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (obs_vec !== model_vec()) begin
      n_bad++; $display("FAIL mid_reset: got %h expected %h", obs_vec, model_vec());
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0);
      pulses += int'(write);
    end
    n_vec++;
    if (pulses != 0 || fifo_count !== '0) begin
      n_bad++; $display("FAIL mid_after: got pulses=%0d cnt=%0d expected 0 0", pulses, fifo_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, ADDR_WIDTH'($urandom), {$urandom, $urandom},
           $urandom_range(0, 1) == 1, ADDR_WIDTH'($urandom), {$urandom, $urandom});
      n_vec++;
      if (obs_vec !== model_vec()) begin
        n_bad++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec, model_vec());
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clock);
    test_reset();
    @(negedge clock);
    reset_n = 1'b1;
    test_single_load();
    test_drain_order();
    test_priority_backpressure();
    test_full_pop();
    test_zero_addr();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges ALU results and memory load results into the single write port of the 32 x 64-bit register bank. Sits directly upstream of the register bank and drives its write enable, write address and write data. Load returns always take priority; ALU results are buffered in a small in-order FIFO and drained whenever the port is free.

## Interface
- DATA_WIDTH, 64, register data width
- ADDR_WIDTH, 5, register address width
- FIFO_DEPTH, 4, ALU result buffer depth; power of two, >= 2

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  FIFO can accept; combinational, equals fifo_count != FIFO_DEPTH
- alu_address  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load result offered; always accepted
- mem_ready  out  1  constant 1
- mem_address  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load data
- write  out  1  register bank write enable, registered
- write_address  out  ADDR_WIDTH  register bank write address, registered
- write_data  out  DATA_WIDTH  register bank write data, registered
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current ALU FIFO occupancy

## Operation
- Push: alu_valid && alu_ready writes {alu_address, alu_data} at the FIFO tail on the rising edge.
- Issue select, evaluated each cycle from the current state:
  - If mem_valid: issue the mem entry.
  - Else if fifo_count > 0: pop the FIFO head and issue it.
  - Else: issue nothing.
- Issue means write=1, write_address and write_data loaded on the next edge. With no issue, write=0 and write_address/write_data hold their previous values.
- At most one write per cycle. ALU results leave in acceptance order.
- A push and a pop may occur in the same cycle; fifo_count is then unchanged.
- When full, alu_ready=0 even if a pop occurs that cycle; no push is taken on that edge.
- Ordering between the two sources is not enforced. Issue logic guarantees that no load and ALU result in flight at the same time target the same register.
- Starvation: continuous mem_valid stalls the FIFO indefinitely. This is intended; back-pressure reaches the ALU through alu_ready.

## Timing
- Load latency: mem accepted at edge N, so write=1 after edge N and the bank commits at edge N+1.
- ALU latency: minimum 2 edges. The result is pushed at edge N and appears on the write outputs after edge N+1 if mem_valid=0 in that cycle.
- reset_n low (asynchronous): write=0, write_address=0, write_data=0, fifo_count=0, FIFO pointers cleared, buffered entries discarded. alu_ready=1 and mem_ready=1 throughout reset.
- Reset deassertion is synchronized externally. The first push is allowed on the first edge with reset_n high.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by fifo_count, not by pointer equality.

## Configuration
- WB_ZERO_GUARD_EN defined: entries targeting address 0 are discarded.
  - A load to x0 is consumed with write=0.
  - An ALU result to x0 is accepted (alu_ready rules unchanged) but not pushed, so fifo_count does not change.
- WB_ZERO_GUARD_EN undefined: address 0 is treated like any other register and written normally.

## Structure
- Package writeback_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH constants
  - typedef wb_entry_t {address, data}
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push, pop, count, asynchronous active-low reset.
- The top level contains the priority select and the output registers.

## Test plan
- Reset mid-stream: 3 ALU entries buffered, reset_n pulsed low -> fifo_count=0, write=0, no further writes after release.
- Single load: mem_valid with address 7, data 0xDEAD_BEEF for one cycle -> write=1 next cycle, address 7, data 0xDEADBEEF, exactly one pulse.
- ALU drain order: push (3,0x11),(4,0x22),(5,0x33) on consecutive cycles with mem idle -> writes to 3, 4, 5 in order, first write 2 edges after the first push.
- Priority and back-pressure: mem_valid held 6 cycles while ALU pushes 5 entries -> 6 mem writes; alu_ready falls after 4 pushes; the 5th entry is accepted once the FIFO drains; the 4 buffered entries then drain in order.
- Full with simultaneous pop: FIFO full, mem idle, alu_valid=1 -> first pop cycle takes no push, fifo_count 4->3, push accepted on the following edge.
- Zero guard (WB_ZERO_GUARD_EN defined): load to address 0 and ALU push to address 0 -> no write pulse, fifo_count stays 0. With the macro undefined -> two writes to address 0.
